// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the upstream adder stage, the frame accumulator and its consumer.
// The operand and total buses are MSB-first ([0:N-1], bit 0 = MSB).
interface sum_accumulator_if #(
  parameter int ACC_W = 12
) ();
  logic [0:3]       sum;
  logic             carry;
  logic             in_valid;
  logic             in_ready;
  logic [0:ACC_W-1] acc_out;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output sum, carry, in_valid, out_ready,
    input  in_ready, acc_out, overflow, out_valid, busy
  );

  modport slave (
    input  sum, carry, in_valid, out_ready,
    output in_ready, acc_out, overflow, out_valid, busy
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT 5-bit {carry,sum} operands per frame into a saturating ACC_W-bit total,
// then holds the total until the consumer takes it.
module sum_accumulator #(
  parameter int COUNT = 16,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0]       COUNT_LAST = 8'(COUNT);
  localparam logic [ACC_W-1:0] ACC_MAX    = {ACC_W{1'b1}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             in_ready_s;
  logic             busy_s;
  logic             out_valid_s;
  logic             xfer_s;
  logic [4:0]       operand_s;
  logic [ACC_W:0]   sum_ext_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; the extra top bit of sum_ext_s flags saturation
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    operand_s = {bus.carry, bus.sum};
    xfer_s    = bus.in_valid & in_ready_s;
    sum_ext_s = {1'b0, acc_q} + (ACC_W+1)'(operand_s);
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (xfer_s) begin
          count_d = count_q + 8'd1;
          if (sum_ext_s[ACC_W]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext_s[ACC_W-1:0];
            ovf_d = ovf_q;
          end
          if (count_d == COUNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          count_d = 8'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        count_d = 8'd0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_ACCUM: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.busy      = busy_s;
  assign bus.out_valid = out_valid_s;
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter COUNT, default 16: number of adder results accumulated per frame; legal range 1..255.
REQ-002 Parameter ACC_W, default 12: accumulator width in bits; legal range 6..32.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port sum, input, 4 ([0:3], bit 0 = MSB): sum output of the upstream 4-bit adder stage.
REQ-006 Port carry, input, 1: carry output of the upstream adder stage; forms bit 4 of the 5-bit operand {carry,sum}, range 0..31.
REQ-007 Port in_valid, input, 1: sum and carry are valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts an operand this cycle.
REQ-009 Port acc_out, output, ACC_W ([0:ACC_W-1], bit 0 = MSB): frame total.
REQ-010 Port overflow, output, 1: frame total saturated.
REQ-011 Port out_valid, output, 1: acc_out and overflow hold a completed frame.
REQ-012 Port out_ready, input, 1: downstream consumes the frame this cycle.
REQ-013 Port busy, output, 1: a frame is partially accumulated.

Function
REQ-014 An input transfer occurs on a rising edge where in_valid=1 and in_ready=1; no transfer occurs otherwise, and sum/carry are ignored.
REQ-015 The FSM has three states: IDLE (count=0, acc=0), ACCUM (0<count<COUNT), DONE (frame complete).
REQ-016 IDLE: in_ready=1, busy=0, out_valid=0; on a transfer, add the operand and move to ACCUM, or to DONE if COUNT=1.
REQ-017 ACCUM: in_ready=1, busy=1; each transfer adds the operand and increments count; the COUNTth transfer moves to DONE.
REQ-018 DONE: in_ready=0, busy=0, out_valid=1; acc_out and overflow hold constant until a rising edge with out_ready=1, which clears acc, count and overflow and returns to IDLE.
REQ-019 Latency: out_valid rises on the edge that registers the COUNTth transfer, so it is visible in the following cycle.
REQ-020 The next frame's first transfer can occur at the earliest in the cycle after the out_valid/out_ready handshake, because in_ready=0 throughout DONE.
REQ-021 Arithmetic: the operand is zero-extended to ACC_W bits and the sum is unsigned.
REQ-022 If an addition would exceed 2^ACC_W-1, acc saturates at 2^ACC_W-1, overflow is set, and overflow stays set for the rest of the frame.
REQ-023 Gaps in in_valid during ACCUM stall accumulation without loss; count and acc hold.
REQ-024 acc_out reflects the running total in every state; downstream treats it as meaningful only when out_valid=1.
REQ-025 The count register is 8 bits wide and never wraps, because COUNT is at most 255.
REQ-026 All outputs are registered or decoded from the state register only; none depends combinationally on in_valid or out_ready.

Reset
REQ-027 rst_n=0 immediately, without waiting for a clock edge, forces IDLE, acc=0, count=0, acc_out=0, overflow=0, out_valid=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-frame or during DONE discards the partial or pending frame; no out_valid pulse follows the release of reset.
REQ-029 After rst_n deasserts, the first rising edge with in_valid=1 is accepted as operand 1 of a new frame.

Verification
REQ-030 Full-scale frame: defaults, 16 back-to-back transfers of carry=1, sum=1111 -> out_valid one cycle after the 16th transfer, acc_out=496, overflow=0.
REQ-031 Saturation: ACC_W=8, same 16 operands -> acc_out=255, overflow=1 from the 9th transfer (9*31=279) until the handshake.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, in_ready=0 and acc_out stable throughout; the handshake on cycle 6 gives IDLE with acc_out=0 the next cycle.
REQ-033 Gapped input: 16 operands of value 1 (carry=0, sum=0001) with in_valid toggling every other cycle -> acc_out=16, out_valid after the 16th accepted transfer only.
REQ-034 Reset mid-frame: pull rst_n low asynchronously after 7 transfers -> outputs zero without a clock edge; a following frame of 16 value-2 operands gives acc_out=32.
REQ-035 COUNT=1: a single transfer of value 5 -> DONE next cycle with acc_out=5; the adder sweep of all 256 {a,b} pairs drives frames whose totals match the reference model.
